// File: rtl/syn_fft_pkg.sv
// -----------------------------------------------------------------------------
// syn_fft_pkg
// Shared definitions for the fusiform_gyrus FFT front end.
//   loader_state_t : sample loader FSM states (IDLE/LOAD/START/WAIT_DONE)
//   bitrev()       : reverses the low 'w' bits of an index (upper bits zero)
//   FRAME_CNT_W    : width of the loaded-frame counter
// -----------------------------------------------------------------------------
package syn_fft_pkg;

    localparam int unsigned FRAME_CNT_W  = 16;
    localparam int unsigned BITREV_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE
    } loader_state_t;

    // Bit reversal over the low w bits; w must not exceed BITREV_MAX_W.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] v,
        input int unsigned             w
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/syn_fgyrus_sample_loader_if.sv
// -----------------------------------------------------------------------------
// syn_fgyrus_sample_loader_if
// PCM sample stream (valid/ready) from the capture FIFO to the sample loader.
//   pcm_valid : sample valid (source)
//   pcm_ready : loader accepts this cycle (sink); valid & ready = accept
//   pcm_data  : two's complement PCM sample, P_PCM_W bits (source)
// Modports: master = PCM source, slave = sample loader.
// -----------------------------------------------------------------------------
interface syn_fgyrus_sample_loader_if #(
    parameter int unsigned P_PCM_W = 16
);
    logic               pcm_valid;
    logic               pcm_ready;
    logic [P_PCM_W-1:0] pcm_data;

    modport master (
        output pcm_valid,
        output pcm_data,
        input  pcm_ready
    );

    modport slave (
        input  pcm_valid,
        input  pcm_data,
        output pcm_ready
    );
endinterface

// File: rtl/syn_fgyrus_pcm_scaler.sv
// -----------------------------------------------------------------------------
// syn_fgyrus_pcm_scaler
// Datapath for the sample loader: sign-extends a PCM sample (or, with
// SYN_FGYRUS_LOADER_DECIM_EN defined, the floor average of a sample pair) to
// P_DATA_W and shifts it left by P_SHIFT. One register stage.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   in_accept : a PCM sample is accepted this cycle
//   in_data   : accepted PCM sample
//   write_now : combinational; this accept produces a cache write next cycle
//   out_data  : registered scaled sample, valid the cycle after write_now
// Macro SYN_FGYRUS_LOADER_DECIM_EN: 2:1 pair-average decimation.
// -----------------------------------------------------------------------------
module syn_fgyrus_pcm_scaler #(
    parameter int unsigned P_PCM_W  = 16,
    parameter int unsigned P_DATA_W = 32,
    parameter int unsigned P_SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_accept,
    input  logic [P_PCM_W-1:0]  in_data,
    output logic                write_now,
    output logic [P_DATA_W-1:0] out_data
);

    logic [P_DATA_W-1:0] ext;

`ifdef SYN_FGYRUS_LOADER_DECIM_EN
    logic               have_half;
    logic [P_PCM_W-1:0] half;
    logic signed [P_PCM_W:0] pair_sum;
    logic signed [P_PCM_W:0] pair_avg;

    // One extra bit holds the pair sum; the arithmetic shift gives a floor
    // average that always fits back into P_PCM_W bits.
    always_comb begin
        pair_sum  = $signed({half[P_PCM_W-1], half}) + $signed({in_data[P_PCM_W-1], in_data});
        pair_avg  = pair_sum >>> 1;
        ext       = {{(P_DATA_W-P_PCM_W-1){pair_avg[P_PCM_W]}}, pair_avg};
        write_now = in_accept & have_half;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_half <= 1'b0;
            half      <= '0;
            out_data  <= '0;
        end else if (in_accept) begin
            if (have_half) begin
                have_half <= 1'b0;
                out_data  <= ext << P_SHIFT;
            end else begin
                have_half <= 1'b1;
                half      <= in_data;
            end
        end
    end
`else
    always_comb begin
        ext       = {{(P_DATA_W-P_PCM_W){in_data[P_PCM_W-1]}}, in_data};
        write_now = in_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (in_accept) begin
            out_data <= ext << P_SHIFT;
        end
    end
`endif

endmodule

// File: rtl/syn_fgyrus_sample_loader.sv
// -----------------------------------------------------------------------------
// syn_fgyrus_sample_loader
// Feeds the FFT ping-pong cache: accepts PCM samples, scales them and writes one
// N = 2**P_ADDR_W point frame at bit-reversed addresses (imag = 0), then pulses
// fft_start and holds until fft_done.
//   clk_ir       : system clock
//   rst_sync_l   : asynchronous active-low reset
//   loader_en    : may start a new frame (sampled in IDLE only)
//   pcm          : PCM valid/ready stream (slave modport)
//   wr_en        : cache write strobe
//   waddr        : cache write address, bitrev(sample index)
//   wr_sample_re : scaled real part
//   wr_sample_im : imaginary part, always 0
//   fft_start    : one-cycle pulse, frame complete in cache
//   fft_done     : one-cycle pulse from FFT FSM, frame consumed
//   loader_busy  : high in every state except IDLE
//   frame_cnt    : frames loaded since reset (wrapping)
// Macro SYN_FGYRUS_LOADER_DECIM_EN: 2:1 decimation, 2N samples per frame.
// -----------------------------------------------------------------------------
module syn_fgyrus_sample_loader
    import syn_fft_pkg::*;
#(
    parameter int unsigned P_PCM_W  = 16,
    parameter int unsigned P_DATA_W = 32,
    parameter int unsigned P_ADDR_W = 8,
    parameter int unsigned P_SHIFT  = 8
) (
    input  logic                   clk_ir,
    input  logic                   rst_sync_l,
    input  logic                   loader_en,
    syn_fgyrus_sample_loader_if.slave pcm,
    output logic                   wr_en,
    output logic [P_ADDR_W-1:0]    waddr,
    output logic [P_DATA_W-1:0]    wr_sample_re,
    output logic [P_DATA_W-1:0]    wr_sample_im,
    output logic                   fft_start,
    input  logic                   fft_done,
    output logic                   loader_busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    loader_state_t       state;
    logic [P_ADDR_W-1:0] idx;
    logic                accept;
    logic                write_now;

    assign pcm.pcm_ready = (state == LOAD);
    assign accept        = pcm.pcm_valid & pcm.pcm_ready;
    assign wr_sample_im  = '0;

    syn_fgyrus_pcm_scaler #(
        .P_PCM_W  (P_PCM_W),
        .P_DATA_W (P_DATA_W),
        .P_SHIFT  (P_SHIFT)
    ) u_scaler (
        .clk       (clk_ir),
        .rst_n     (rst_sync_l),
        .in_accept (accept),
        .in_data   (pcm.pcm_data),
        .write_now (write_now),
        .out_data  (wr_sample_re)
    );

    // wr_en/waddr are registered on the accept edge so they line up with the
    // scaler's registered data. The FSM leaves LOAD on that same edge, so the
    // last write happens while in START and fft_start follows one cycle later.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state       <= IDLE;
            idx         <= '0;
            wr_en       <= 1'b0;
            waddr       <= '0;
            fft_start   <= 1'b0;
            loader_busy <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            wr_en     <= write_now;
            fft_start <= 1'b0;
            if (write_now) begin
                waddr <= P_ADDR_W'(bitrev(BITREV_MAX_W'(idx), P_ADDR_W));
                idx   <= idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (loader_en) begin
                        state       <= LOAD;
                        loader_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (write_now && (idx == '1)) begin
                        state <= START;
                    end
                end
                START: begin
                    state     <= WAIT_DONE;
                    fft_start <= 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (fft_done) begin
                        state       <= IDLE;
                        loader_busy <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    loader_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syn_fgyrus_sample_loader.sv
// -----------------------------------------------------------------------------
// tb_syn_fgyrus_sample_loader
// Directed bench for syn_fgyrus_sample_loader (N = 256, 16-bit PCM, 32-bit
// cache, shift 8). A negedge monitor logs cache writes and fft_start pulses;
// each scenario task drives its stimulus and checks the log against
// hand-derived values.
// -----------------------------------------------------------------------------
module tb_syn_fgyrus_sample_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loader_en;
    logic        fft_done;
    logic        wr_en;
    logic [7:0]  waddr;
    logic [31:0] wr_sample_re;
    logic [31:0] wr_sample_im;
    logic        fft_start;
    logic        loader_busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    syn_fgyrus_sample_loader_if #(.P_PCM_W(16)) pcm_if ();

    syn_fgyrus_sample_loader #(
        .P_PCM_W  (16),
        .P_DATA_W (32),
        .P_ADDR_W (8),
        .P_SHIFT  (8)
    ) dut (
        .clk_ir       (clk),
        .rst_sync_l   (rst_n),
        .loader_en    (loader_en),
        .pcm          (pcm_if),
        .wr_en        (wr_en),
        .waddr        (waddr),
        .wr_sample_re (wr_sample_re),
        .wr_sample_im (wr_sample_im),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .loader_busy  (loader_busy),
        .frame_cnt    (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    int          cyc       = 0;
    int          start_cnt = 0;
    int          start_cyc = -1;
    logic [7:0]  wq_addr[$];
    logic [31:0] wq_re[$];
    logic [31:0] wq_im[$];
    int          wq_cyc[$];
    logic [15:0] stim[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_en === 1'b1) begin
                wq_addr.push_back(waddr);
                wq_re.push_back(wr_sample_re);
                wq_im.push_back(wr_sample_im);
                wq_cyc.push_back(cyc);
            end
            if (fft_start === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] rev8(input int k);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = k[7-b];
        return r;
    endfunction

    function automatic logic [31:0] scaled(input logic [15:0] x);
        logic [31:0] e;
        e = {{16{x[15]}}, x};
        return e << 8;
    endfunction

    task automatic clear_mon();
        wq_addr.delete();
        wq_re.delete();
        wq_im.delete();
        wq_cyc.delete();
        start_cnt = 0;
        start_cyc = -1;
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
    endtask

    // Offers stim[] until n samples are accepted or the cycle budget runs out.
    task automatic drive_stream(input int n, input bit gaps, output int sent);
        int cycles;
        bit vld;
        bit rdy;
        cycles = 0;
        sent   = 0;
        while (sent < n && cycles < 4000) begin
            vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pcm_if.pcm_valid = vld;
            pcm_if.pcm_data  = stim[sent];
            rdy = pcm_if.pcm_ready;
            @(posedge clk);
            if (vld && rdy) sent++;
            #1;
            cycles++;
        end
        pcm_if.pcm_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; loader_en = 1'b0; fft_done = 1'b0;
        pcm_if.pcm_valid = 1'b0; pcm_if.pcm_data = '0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (wr_en !== 1'b0)          begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (waddr !== 8'h00)         begin bad++; $display("FAIL reset_waddr got=%h exp=00", waddr); end
        total++; if (wr_sample_re !== 32'h0)  begin bad++; $display("FAIL reset_re got=%h exp=0", wr_sample_re); end
        total++; if (wr_sample_im !== 32'h0)  begin bad++; $display("FAIL reset_im got=%h exp=0", wr_sample_im); end
        total++; if (fft_start !== 1'b0)      begin bad++; $display("FAIL reset_fft_start got=%b exp=0", fft_start); end
        total++; if (loader_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", loader_busy); end
        total++; if (frame_cnt !== 16'h0)     begin bad++; $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt); end
        total++; if (pcm_if.pcm_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", pcm_if.pcm_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int sent;
        int nerr;
        clear_mon();
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(16'(i));
        loader_en = 1'b1;
        drive_stream(256, 1'b0, sent);
        repeat (5) @(posedge clk);
        #1;
        total++; if (sent !== 256) begin bad++; $display("FAIL ff_accepted got=%0d exp=256", sent); end
        total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL ff_write_count got=%0d exp=256", wq_addr.size()); end
        nerr = 0;
        for (int k = 0; k < wq_addr.size() && k < 256; k++) begin
            if (wq_addr[k] !== rev8(k) || wq_re[k] !== 32'(k) << 8 || wq_im[k] !== 32'h0) begin
                nerr++;
                if (nerr < 8) $display("FAIL ff_write[%0d] got addr=%h re=%h im=%h exp addr=%h re=%h im=0",
                                        k, wq_addr[k], wq_re[k], wq_im[k], rev8(k), 32'(k) << 8);
            end
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL ff_write_errors got=%0d exp=0", nerr); end
        if (wq_addr.size() > 2) begin
            total++; if (wq_addr[1] !== 8'h80) begin bad++; $display("FAIL ff_addr_idx1 got=%h exp=80", wq_addr[1]); end
            total++; if (wq_addr[2] !== 8'h40) begin bad++; $display("FAIL ff_addr_idx2 got=%h exp=40", wq_addr[2]); end
        end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL ff_start_count got=%0d exp=1", start_cnt); end
        if (wq_cyc.size() > 0) begin
            total++; if (start_cyc !== wq_cyc[$] + 1) begin bad++; $display("FAIL ff_start_timing got=%0d exp=%0d", start_cyc, wq_cyc[$] + 1); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL ff_frame_cnt got=%0d exp=1", frame_cnt); end
        total++; if (loader_busy !== 1'b1) begin bad++; $display("FAIL ff_busy_wait got=%b exp=1", loader_busy); end
    endtask

    task automatic test_wait_done_hold();
        int wr0;
        int rdy_err;
        wr0 = wq_addr.size();
        rdy_err = 0;
        pcm_if.pcm_valid = 1'b1;
        pcm_if.pcm_data  = 16'h1234;
        repeat (100) begin
            if (pcm_if.pcm_ready !== 1'b0) rdy_err++;
            @(posedge clk); #1;
        end
        pcm_if.pcm_valid = 1'b0;
        total++; if (rdy_err !== 0) begin bad++; $display("FAIL wd_ready_cycles got=%0d exp=0", rdy_err); end
        total++; if (wq_addr.size() !== wr0) begin bad++; $display("FAIL wd_writes got=%0d exp=%0d", wq_addr.size(), wr0); end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL wd_start_count got=%0d exp=1", start_cnt); end
        loader_en = 1'b0;
        pulse_done();
        repeat (3) @(posedge clk);
        #1;
        total++; if (loader_busy !== 1'b0) begin bad++; $display("FAIL wd_busy_after_done got=%b exp=0", loader_busy); end
        total++; if (pcm_if.pcm_ready !== 1'b0) begin bad++; $display("FAIL wd_ready_idle got=%b exp=0", pcm_if.pcm_ready); end
    endtask

    task automatic test_random_gaps();
        int sent;
        int nerr;
        clear_mon();
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(16'(i));
        loader_en = 1'b1;
        drive_stream(256, 1'b1, sent);
        repeat (5) @(posedge clk);
        #1;
        total++; if (sent !== 256) begin bad++; $display("FAIL gap_accepted got=%0d exp=256", sent); end
        total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL gap_write_count got=%0d exp=256", wq_addr.size()); end
        nerr = 0;
        for (int k = 0; k < wq_addr.size() && k < 256; k++) begin
            if (wq_addr[k] !== rev8(k) || wq_re[k] !== 32'(k) << 8 || wq_im[k] !== 32'h0) begin
                nerr++;
                if (nerr < 8) $display("FAIL gap_write[%0d] got addr=%h re=%h exp addr=%h re=%h",
                                        k, wq_addr[k], wq_re[k], rev8(k), 32'(k) << 8);
            end
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL gap_write_errors got=%0d exp=0", nerr); end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL gap_start_count got=%0d exp=1", start_cnt); end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL gap_frame_cnt got=%0d exp=2", frame_cnt); end
        loader_en = 1'b0;
        pulse_done();
    endtask

    // Extreme sample values, and fft_done held high through LOAD and the
    // final-write cycle: it must not release the loader from WAIT_DONE.
    task automatic test_extremes();
        int sent;
        clear_mon();
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(16'(i));
        stim[0] = 16'h8000;
        stim[1] = 16'h7FFF;
        stim[2] = 16'hFFFF;
        loader_en = 1'b1;
        fft_done  = 1'b1;
        drive_stream(256, 1'b0, sent);
        @(posedge clk); #1;
        fft_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL ext_write_count got=%0d exp=256", wq_addr.size()); end
        if (wq_re.size() > 3) begin
            total++; if (wq_re[0] !== 32'hFF800000) begin bad++; $display("FAIL ext_min got=%h exp=ff800000", wq_re[0]); end
            total++; if (wq_re[1] !== 32'h007FFF00) begin bad++; $display("FAIL ext_max got=%h exp=007fff00", wq_re[1]); end
            total++; if (wq_re[2] !== 32'hFFFFFF00) begin bad++; $display("FAIL ext_minus1 got=%h exp=ffffff00", wq_re[2]); end
            total++; if (wq_re[3] !== 32'h00000300) begin bad++; $display("FAIL ext_three got=%h exp=00000300", wq_re[3]); end
        end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL ext_start_count got=%0d exp=1", start_cnt); end
        total++; if (loader_busy !== 1'b1) begin bad++; $display("FAIL ext_done_ignored got busy=%b exp=1", loader_busy); end
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL ext_frame_cnt got=%0d exp=3", frame_cnt); end
        loader_en = 1'b0;
        pulse_done();
    endtask

    task automatic test_reset_mid_frame();
        int sent;
        clear_mon();
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(16'(i + 1));
        loader_en = 1'b1;
        drive_stream(100, 1'b0, sent);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || waddr !== 8'h00 || loader_busy !== 1'b0 || frame_cnt !== 16'h0)
            begin bad++; $display("FAIL rmf_async_clear got wr_en=%b waddr=%h busy=%b frame_cnt=%0d exp all 0",
                                   wr_en, waddr, loader_busy, frame_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (start_cnt !== 0) begin bad++; $display("FAIL rmf_partial_start got=%0d exp=0", start_cnt); end
        clear_mon();
        drive_stream(256, 1'b0, sent);
        repeat (5) @(posedge clk);
        #1;
        total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL rmf_write_count got=%0d exp=256", wq_addr.size()); end
        if (wq_addr.size() > 1) begin
            total++; if (wq_addr[0] !== 8'h00 || wq_re[0] !== 32'h00000100)
                begin bad++; $display("FAIL rmf_first_write got addr=%h re=%h exp addr=00 re=00000100", wq_addr[0], wq_re[0]); end
            total++; if (wq_addr[1] !== 8'h80) begin bad++; $display("FAIL rmf_second_addr got=%h exp=80", wq_addr[1]); end
        end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL rmf_start_count got=%0d exp=1", start_cnt); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rmf_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    // Pairs (4,6),(-3,-4) then (i,i+1) for even i from 4: floor averages
    // 5, -4, then i.
    task automatic test_decim();
        int sent;
        int nerr;
        logic [31:0] exp_re;
        clear_mon();
        stim.delete();
        stim.push_back(16'd4);
        stim.push_back(16'd6);
        stim.push_back(16'hFFFD);
        stim.push_back(16'hFFFC);
        for (int i = 4; i < 512; i++) stim.push_back(16'(i));
        loader_en = 1'b1;
        drive_stream(512, 1'b0, sent);
        repeat (5) @(posedge clk);
        #1;
        total++; if (sent !== 512) begin bad++; $display("FAIL dec_accepted got=%0d exp=512", sent); end
        total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL dec_write_count got=%0d exp=256", wq_addr.size()); end
        if (wq_re.size() > 1) begin
            total++; if (wq_re[0] !== 32'h00000500) begin bad++; $display("FAIL dec_pair0 got=%h exp=00000500", wq_re[0]); end
            total++; if (wq_re[1] !== 32'hFFFFFC00) begin bad++; $display("FAIL dec_pair1 got=%h exp=fffffc00", wq_re[1]); end
        end
        nerr = 0;
        for (int k = 2; k < wq_addr.size() && k < 256; k++) begin
            exp_re = 32'(2 * k) << 8;
            if (wq_addr[k] !== rev8(k) || wq_re[k] !== exp_re) begin
                nerr++;
                if (nerr < 8) $display("FAIL dec_write[%0d] got addr=%h re=%h exp addr=%h re=%h",
                                        k, wq_addr[k], wq_re[k], rev8(k), exp_re);
            end
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL dec_write_errors got=%0d exp=0", nerr); end
        total++; if (start_cnt !== 1) begin bad++; $display("FAIL dec_start_count got=%0d exp=1", start_cnt); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL dec_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        loader_en = 1'b0;
        fft_done = 1'b0;
        pcm_if.pcm_valid = 1'b0;
        pcm_if.pcm_data = '0;
        test_reset();
`ifdef SYN_FGYRUS_LOADER_DECIM_EN
        test_decim();
`else
        test_full_frame();
        test_wait_done_hold();
        test_random_gaps();
        test_extremes();
        test_reset_mid_frame();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
